ram_responder: RTL
==================

Name: ram_responder

Overview:
- Memory-side end of the word-wide RAM request/valid interface that the team's write-back caches drive as initiator.
- Accepts single-cycle read or write strobes and services one request at a time after a fixed, parameterised latency.
- Confirms each access with a one-cycle ram_data_valid pulse.
- Serves as the backing store for cache simulation, and as the RAM stub in integration builds.

Parameters:
- ADDRESS_WIDTH, 16, byte address width. Word index is ram_address[ADDRESS_WIDTH-1:2]. Depth is 2**(ADDRESS_WIDTH-2) words of 32 bits.
- LATENCY, 3, cycles from accepted strobe to ram_data_valid. Must be at least 1; elaboration fails with $fatal otherwise.
- INIT_FILE, "", if non-empty, memory is loaded with $readmemh at time zero.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- ram_address  input  ADDRESS_WIDTH  byte address of the request; bits [1:0] are ignored
- ram_rd  input  1  read strobe
- ram_wr  input  1  write strobe
- ram_data_wr  input  32  write data, sampled with ram_wr
- ram_data_rd  output  32  read data, valid when ram_data_valid is high
- ram_data_valid  output  1  one-cycle completion pulse for reads and writes
- busy  output  1  high while a request is outstanding
- protocol_error  output  1  one-cycle pulse flagging an illegal strobe

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: ram_data_rd=0, ram_data_valid=0, busy=0, protocol_error=0, state IDLE, latency counter 0.
- Memory contents are not reset.
- States:
  - IDLE: a legal strobe (exactly one of ram_rd or ram_wr high) latches address, op and ram_data_wr. Counter loads LATENCY-1, busy goes high next cycle, state goes to WAIT.
  - WAIT: the counter decrements each cycle. When it is 0, the access is performed on that edge: a read loads ram_data_rd from mem[word], a write stores ram_data_wr into mem[word]. On the same edge ram_data_valid is set for one cycle, busy clears and state returns to IDLE.
- Timing: a strobe in cycle T gives ram_data_valid high in cycle T+LATENCY only.
- A write is visible to any read strobed in or after its valid cycle.
- A strobe coincident with ram_data_valid is accepted, since state is already IDLE. This supports back-to-back line bursts where the initiator re-strobes in the cycle after valid.
- ram_data_rd holds the last read value; writes do not change it.
- Strobe while busy: ignored. protocol_error is high the following cycle for one cycle. The outstanding request is unaffected.
- ram_rd and ram_wr high together in IDLE: no access, state stays IDLE, protocol_error pulses.
- A strobe held high for several cycles counts as one strobe per cycle. Extra cycles while busy raise protocol_error as above.
- Address wrap: none. Every ADDRESS_WIDTH-bit address maps to a unique word.
- Reset mid-request: the pending access is dropped, no write commit, no valid. Outputs take reset values immediately on rst_n falling.

Optional Feature:
- Macro: RAM_RANDOM_STALL_EN.
- When defined:
  - An 8-bit LFSR, seeded 8'hA5 on reset, polynomial x^8+x^6+x^5+x^4+1, advances every cycle.
  - On strobe acceptance the counter loads LATENCY-1+lfsr[1:0], so valid lands at T+LATENCY+{0..3}.
  - Purpose: stressing initiators.
- When undefined: no LFSR, fixed latency exactly as above.

Test Plan:
- Read latency: LATENCY=3, preload mem[0x10]=32'hDEADBEEF, ram_rd at T with address 16'h0040 -> ram_data_valid high only at T+3, ram_data_rd=32'hDEADBEEF, busy high T+1..T+2.
- Write then read: ram_wr with address 16'h0044, data 32'h12345678 at T. ram_rd to 16'h0044 strobed at T+3, the valid cycle -> read valid at T+6 with 32'h12345678.
- Cache-style burst: read strobes to 16'h0100, 16'h0104, 16'h0108, 16'h010C, each re-strobed the cycle after the previous valid -> four valid pulses spaced 4 cycles apart, preloaded data in order, protocol_error never set.
- Strobe while busy: ram_rd at T and again at T+1 -> protocol_error high at T+2 only, a single valid at T+3.
- Conflicting strobes: ram_rd=ram_wr=1 at T with data 32'hFFFFFFFF -> protocol_error at T+1, no valid, memory word unchanged on readback.
- Reset mid-op: ram_wr at T, rst_n low at T+1 for 2 cycles -> busy=0 immediately, no valid ever, memory word retains its old value.

Source files
------------

// File: rtl/ram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ram_responder
// Purpose  : Memory-side responder for the word-wide RAM request/valid
//            interface driven by the write-back caches. It accepts one
//            single-cycle read or write strobe at a time. After LATENCY cycles
//            it completes the access and pulses ram_data_valid.
// Ports    : clk            - clock
//            rst_n          - asynchronous, active-low reset
//            ram_address    - byte address; bits [1:0] ignored
//            ram_rd/ram_wr  - read / write strobes (exactly one is legal)
//            ram_data_wr    - write data, sampled with ram_wr
//            ram_data_rd    - read data, holds last read value
//            ram_data_valid - one-cycle completion pulse
//            busy           - high while a request is outstanding
//            protocol_error - one-cycle pulse after an illegal strobe
// Options  : RAM_RANDOM_STALL_EN - adds 0..3 LFSR-chosen stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module ram_responder #(
    parameter int    ADDRESS_WIDTH = 16,
    parameter int    LATENCY       = 3,
    parameter string INIT_FILE     = ""
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] ram_address,
    input  logic                     ram_rd,
    input  logic                     ram_wr,
    input  logic [31:0]              ram_data_wr,
    output logic [31:0]              ram_data_rd,
    output logic                     ram_data_valid,
    output logic                     busy,
    output logic                     protocol_error
);

    localparam int WORD_W = ADDRESS_WIDTH - 2;
    localparam int DEPTH  = 2 ** WORD_W;
`ifdef RAM_RANDOM_STALL_EN
    localparam int MAX_EXTRA = 3;
`else
    localparam int MAX_EXTRA = 0;
`endif
    // Counter holds the number of wait cycles still to run; +2 keeps it at
    // least one bit wide for every legal LATENCY.
    localparam int CNT_W = $clog2(LATENCY + MAX_EXTRA + 2);

    generate
        if (LATENCY < 1) begin : g_latency_check
            $fatal(1, "ram_responder: LATENCY must be at least 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    logic [31:0]       mem [DEPTH];

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  load_val;
    logic [WORD_W-1:0] word_q;
    logic              wr_q;
    logic [31:0]       data_q;

    logic              accept;
    logic              access;
    logic              err_next;
    logic [WORD_W-1:0] acc_word;
    logic              acc_wr;
    logic [31:0]       acc_data;
    logic [WORD_W-1:0] in_word;
    logic              unused_addr_bits;

    assign in_word          = ram_address[ADDRESS_WIDTH-1:2];
    assign unused_addr_bits = ^ram_address[1:0];
    assign busy             = (state == ST_WAIT);

`ifdef RAM_RANDOM_STALL_EN
    // x^8+x^6+x^5+x^4+1, Fibonacci form, free-running.
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign load_val = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
    assign load_val = CNT_W'(LATENCY - 1);
`endif

    // Next-state logic. A request whose wait count is zero (LATENCY of 1 with
    // no stall) completes on the accepting edge itself, using the live inputs.
    // Otherwise it is parked in WAIT and completes on the edge where the
    // count steps from 1 to 0. Valid then lands exactly LATENCY cycles after
    // the strobe.
    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        access     = 1'b0;
        err_next   = 1'b0;
        acc_word   = word_q;
        acc_wr     = wr_q;
        acc_data   = data_q;
        case (state)
            ST_IDLE: begin
                err_next = ram_rd & ram_wr;
                if (ram_rd ^ ram_wr) begin
                    accept = 1'b1;
                    if (load_val == '0) begin
                        access   = 1'b1;
                        acc_word = in_word;
                        acc_wr   = ram_wr;
                        acc_data = ram_data_wr;
                    end else begin
                        state_next = ST_WAIT;
                        count_next = load_val;
                    end
                end
            end
            ST_WAIT: begin
                err_next   = ram_rd | ram_wr;
                count_next = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    access     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            count          <= '0;
            word_q         <= '0;
            wr_q           <= 1'b0;
            data_q         <= '0;
            ram_data_rd    <= '0;
            ram_data_valid <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            state          <= state_next;
            count          <= count_next;
            ram_data_valid <= access;
            protocol_error <= err_next;
            if (accept) begin
                word_q <= in_word;
                wr_q   <= ram_wr;
                data_q <= ram_data_wr;
            end
            if (access && !acc_wr) begin
                ram_data_rd <= mem[acc_word];
            end
        end
    end

    // Storage is never reset. The rst_n term keeps a strobe during reset from
    // committing through the zero-wait path.
    always_ff @(posedge clk) begin
        if (access && acc_wr && rst_n) begin
            mem[acc_word] <= acc_data;
        end
    end

endmodule
`default_nettype wire
